tag_port_scheduler: RTL and testbench

Single-port scheduler for one cache bank's tag store. It arbitrates the store's one read/write port between three requesters: a line-walk flush engine, memory fills (with the software-prefetch flag) and core lookups. It returns one lookup response per granted lookup. It sits between the bank pipeline/MSHR and the tag-access block, and optionally keeps prefetch-effectiveness counters.

---
 rtl/tag_port_scheduler.sv | 176 +++++++++++++++++
 tb/tb_tag_port_scheduler.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_port_scheduler.sv
// tag_port_scheduler
// Single-port scheduler for one cache bank's tag store. It shares the
// store's single read/write port between three requesters:
//   - a flush walk that invalidates every line after reset or flush_all
//   - memory fills, which always win over lookups
//   - core lookups, which get one response in the cycle after the grant
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   stall                 blocks new lookup grants only (fills still accepted)
//   flush_all             pulse; starts a full flush walk from RUN
//   init_done             high while no flush walk is in progress
//   fill_*                fill request/accept, line address, prefetch flag
//   lookup_*              lookup request/accept, line address
//   rsp_*                 lookup response (valid, hit, prefetched, address)
//   ts_*                  tag-store controls and address; ts_tag_match and
//                         ts_prefetched come back one cycle after ts_lookup
//   pf_fill_count         number of accepted prefetch fills
//   pf_hit_count          number of responses that hit a prefetched line
//
// Configuration macro: PREFETCH_STATS_EN builds the two 32-bit prefetch
// counters. When it is not defined, both count outputs are tied to zero.
module tag_port_scheduler #(
    parameter int LINES_PER_BANK  = 64,
    parameter int LINE_ADDR_WIDTH = 26
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       flush_all,
    output logic                       init_done,
    input  logic                       fill_valid,
    output logic                       fill_ready,
    input  logic [LINE_ADDR_WIDTH-1:0] fill_addr,
    input  logic                       fill_prefetch,
    input  logic                       lookup_valid,
    output logic                       lookup_ready,
    input  logic [LINE_ADDR_WIDTH-1:0] lookup_addr,
    output logic                       rsp_valid,
    output logic                       rsp_hit,
    output logic                       rsp_prefetched,
    output logic [LINE_ADDR_WIDTH-1:0] rsp_addr,
    output logic                       ts_lookup,
    output logic                       ts_fill,
    output logic                       ts_flush,
    output logic                       ts_write_prefetch,
    output logic [LINE_ADDR_WIDTH-1:0] ts_addr,
    input  logic                       ts_tag_match,
    input  logic                       ts_prefetched,
    output logic [31:0]                pf_fill_count,
    output logic [31:0]                pf_hit_count
);

    localparam int IDX_W = $clog2(LINES_PER_BANK);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINES_PER_BANK - 1);

    typedef enum logic {
        WALK,
        RUN
    } state_t;

    state_t                     state_q, state_d;
    logic [IDX_W-1:0]           walkCnt_q, walkCnt_d;
    logic                       rspPending_q, rspPending_d;
    logic [LINE_ADDR_WIDTH-1:0] rspAddr_q, rspAddr_d;
    logic                       fillGrant;
    logic                       lookupGrant;

    // Port arbitration and next-state logic. Everything is gated by reset so
    // the reset cycle itself issues no store operation and grants nothing.
    always_comb begin
        state_d           = state_q;
        walkCnt_d         = walkCnt_q;
        rspPending_d      = 1'b0;
        rspAddr_d         = rspAddr_q;
        fillGrant         = 1'b0;
        lookupGrant       = 1'b0;
        init_done         = 1'b0;
        fill_ready        = 1'b0;
        lookup_ready      = 1'b0;
        ts_lookup         = 1'b0;
        ts_fill           = 1'b0;
        ts_flush          = 1'b0;
        ts_write_prefetch = 1'b0;
        ts_addr           = '0;

        if (!reset) begin
            case (state_q)
                WALK: begin
                    // Walk counter is exactly IDX_W bits wide, so it wraps
                    // back to zero on its own after the last line.
                    ts_flush  = 1'b1;
                    ts_addr   = LINE_ADDR_WIDTH'(walkCnt_q);
                    walkCnt_d = walkCnt_q + IDX_W'(1);
                    if (walkCnt_q == LAST_IDX) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    init_done   = 1'b1;
                    fillGrant   = fill_valid;
                    lookupGrant = lookup_valid & ~fill_valid & ~stall;
                    if (fillGrant) begin
                        ts_fill           = 1'b1;
                        ts_write_prefetch = fill_prefetch;
                        ts_addr           = fill_addr;
                    end else if (lookupGrant) begin
                        ts_lookup = 1'b1;
                        ts_addr   = lookup_addr;
                    end
                    if (flush_all) begin
                        state_d   = WALK;
                        walkCnt_d = '0;
                    end
                end
            endcase
        end

        fill_ready   = fillGrant;
        lookup_ready = lookupGrant;

        // The store answers one cycle after ts_lookup, so remember that a
        // response is due and which address it belongs to.
        rspPending_d = lookupGrant;
        if (lookupGrant) begin
            rspAddr_d = lookup_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= WALK;
            walkCnt_q    <= '0;
            rspPending_q <= 1'b0;
            rspAddr_q    <= '0;
        end else begin
            state_q      <= state_d;
            walkCnt_q    <= walkCnt_d;
            rspPending_q <= rspPending_d;
            rspAddr_q    <= rspAddr_d;
        end
    end

    // A lookup granted just before reset loses its response.
    assign rsp_valid      = rspPending_q & ~reset;
    assign rsp_hit        = rsp_valid & ts_tag_match;
    assign rsp_prefetched = rsp_hit & ts_prefetched;
    assign rsp_addr       = rspAddr_q;

`ifdef PREFETCH_STATS_EN
    logic [31:0] pfFillCount_q;
    logic [31:0] pfHitCount_q;

    // Free-running statistics; flush_all deliberately leaves them alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            pfFillCount_q <= '0;
            pfHitCount_q  <= '0;
        end else begin
            if (fillGrant && fill_prefetch) begin
                pfFillCount_q <= pfFillCount_q + 32'd1;
            end
            if (rsp_prefetched) begin
                pfHitCount_q <= pfHitCount_q + 32'd1;
            end
        end
    end

    assign pf_fill_count = pfFillCount_q;
    assign pf_hit_count  = pfHitCount_q;
`else
    assign pf_fill_count = '0;
    assign pf_hit_count  = '0;
`endif

endmodule

// File: tb/tb_tag_port_scheduler.sv
// tb_tag_port_scheduler
// Testbench for tag_port_scheduler. A small tag-store emulation answers the
// DUT's ts_* operations. A reference model of the scheduler checks every
// output each cycle. The model tracks walk progress, grant priority, an
// expected tag-store image and the prefetch statistics. Stimulus is a few
// directed sequences followed by randomized traffic.
module tb_tag_port_scheduler;

    localparam int LINES = 64;
    localparam int AW    = 26;
    localparam int IDXW  = 6;
    localparam int TAGW  = AW - IDXW;

    logic          clk = 1'b0;
    logic          reset;
    logic          stall;
    logic          flush_all;
    logic          init_done;
    logic          fill_valid;
    logic          fill_ready;
    logic [AW-1:0] fill_addr;
    logic          fill_prefetch;
    logic          lookup_valid;
    logic          lookup_ready;
    logic [AW-1:0] lookup_addr;
    logic          rsp_valid;
    logic          rsp_hit;
    logic          rsp_prefetched;
    logic [AW-1:0] rsp_addr;
    logic          ts_lookup;
    logic          ts_fill;
    logic          ts_flush;
    logic          ts_write_prefetch;
    logic [AW-1:0] ts_addr;
    logic          ts_tag_match = 1'b0;
    logic          ts_prefetched = 1'b0;
    logic [31:0]   pf_fill_count;
    logic [31:0]   pf_hit_count;

    int tests    = 0;
    int failures = 0;

    // Reference model state
    bit            mWalk;
    int            mIdx;
    bit            mPend;
    bit            mPendHit;
    bit            mPendPf;
    logic [AW-1:0] mPendAddr;
    logic [31:0]   mFillCnt;
    logic [31:0]   mHitCnt;
    bit            refValid [LINES];
    logic [TAGW-1:0] refTag [LINES];
    bit            refPf    [LINES];

    // Tag-store emulation
    bit            envValid [LINES];
    logic [TAGW-1:0] envTag [LINES];
    bit            envPf    [LINES];

    always #5 clk = ~clk;

    tag_port_scheduler #(
        .LINES_PER_BANK (LINES),
        .LINE_ADDR_WIDTH(AW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .flush_all        (flush_all),
        .init_done        (init_done),
        .fill_valid       (fill_valid),
        .fill_ready       (fill_ready),
        .fill_addr        (fill_addr),
        .fill_prefetch    (fill_prefetch),
        .lookup_valid     (lookup_valid),
        .lookup_ready     (lookup_ready),
        .lookup_addr      (lookup_addr),
        .rsp_valid        (rsp_valid),
        .rsp_hit          (rsp_hit),
        .rsp_prefetched   (rsp_prefetched),
        .rsp_addr         (rsp_addr),
        .ts_lookup        (ts_lookup),
        .ts_fill          (ts_fill),
        .ts_flush         (ts_flush),
        .ts_write_prefetch(ts_write_prefetch),
        .ts_addr          (ts_addr),
        .ts_tag_match     (ts_tag_match),
        .ts_prefetched    (ts_prefetched),
        .pf_fill_count    (pf_fill_count),
        .pf_hit_count     (pf_hit_count)
    );

    // Tag store: writes land on the edge of the operation cycle, lookup
    // results appear in the following cycle.
    always @(posedge clk) begin
        if (ts_lookup) begin
            ts_tag_match  <= envValid[ts_addr[IDXW-1:0]] && (envTag[ts_addr[IDXW-1:0]] == ts_addr[AW-1:IDXW]);
            ts_prefetched <= envPf[ts_addr[IDXW-1:0]];
        end
        if (ts_fill) begin
            envValid[ts_addr[IDXW-1:0]] <= 1'b1;
            envTag[ts_addr[IDXW-1:0]]   <= ts_addr[AW-1:IDXW];
            envPf[ts_addr[IDXW-1:0]]    <= ts_write_prefetch;
        end
        if (ts_flush) begin
            envValid[ts_addr[IDXW-1:0]] <= 1'b0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, check all outputs against the model, then
    // advance the model and the clock.
    task automatic applyStimulus(input bit r, input bit fl, input bit fv, input logic [AW-1:0] fa,
                                 input bit fp, input bit lv, input logic [AW-1:0] la, input bit st);
        bit            eFlush, eFill, eLook, eWpf, eFr, eLr, eInit, eRv;
        logic [AW-1:0] eAddr;
        int            li;

        reset         = r;
        flush_all     = fl;
        fill_valid    = fv;
        fill_addr     = fa;
        fill_prefetch = fp;
        lookup_valid  = lv;
        lookup_addr   = la;
        stall         = st;
        #4;

        eFlush = 0; eFill = 0; eLook = 0; eWpf = 0; eFr = 0; eLr = 0; eInit = 0;
        eAddr  = '0;
        if (!r) begin
            if (mWalk) begin
                eFlush = 1;
                eAddr  = AW'(mIdx);
            end else begin
                eInit = 1;
                eFr   = fv;
                eLr   = lv && !fv && !st;
                if (eFr) begin
                    eFill = 1;
                    eWpf  = fp;
                    eAddr = fa;
                end else if (eLr) begin
                    eLook = 1;
                    eAddr = la;
                end
            end
        end
        eRv = mPend && !r;

        checkOutput("ts_flush", 32'(ts_flush), 32'(eFlush));
        checkOutput("ts_fill", 32'(ts_fill), 32'(eFill));
        checkOutput("ts_lookup", 32'(ts_lookup), 32'(eLook));
        checkOutput("ts_write_prefetch", 32'(ts_write_prefetch), 32'(eWpf));
        checkOutput("ts_addr", 32'(ts_addr), 32'(eAddr));
        checkOutput("fill_ready", 32'(fill_ready), 32'(eFr));
        checkOutput("lookup_ready", 32'(lookup_ready), 32'(eLr));
        checkOutput("init_done", 32'(init_done), 32'(eInit));
        checkOutput("rsp_valid", 32'(rsp_valid), 32'(eRv));
        if (eRv) begin
            checkOutput("rsp_hit", 32'(rsp_hit), 32'(mPendHit));
            checkOutput("rsp_prefetched", 32'(rsp_prefetched), 32'(mPendHit && mPendPf));
            checkOutput("rsp_addr", 32'(rsp_addr), 32'(mPendAddr));
        end
`ifdef PREFETCH_STATS_EN
        checkOutput("pf_fill_count", pf_fill_count, mFillCnt);
        checkOutput("pf_hit_count", pf_hit_count, mHitCnt);
`else
        checkOutput("pf_fill_count", pf_fill_count, 32'd0);
        checkOutput("pf_hit_count", pf_hit_count, 32'd0);
`endif

        if (r) begin
            mWalk    = 1;
            mIdx     = 0;
            mPend    = 0;
            mFillCnt = 0;
            mHitCnt  = 0;
        end else begin
            if (eRv && mPendHit && mPendPf) mHitCnt++;
            if (eFill && fp) mFillCnt++;
            mPend = eLook;
            if (eLook) begin
                li        = int'(la[IDXW-1:0]);
                mPendAddr = la;
                mPendHit  = refValid[li] && (refTag[li] == la[AW-1:IDXW]);
                mPendPf   = refPf[li];
            end
            if (eFill) begin
                li           = int'(fa[IDXW-1:0]);
                refValid[li] = 1;
                refTag[li]   = fa[AW-1:IDXW];
                refPf[li]    = fp;
            end
            if (eFlush) refValid[mIdx] = 0;
            if (mWalk) begin
                mIdx++;
                if (mIdx == LINES) mWalk = 0;
            end else if (fl) begin
                mWalk = 1;
                mIdx  = 0;
            end
        end

        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, '0, 0, 0, '0, 0);
    endtask

    function automatic logic [AW-1:0] mkAddr(input int tag, input int idx);
        return (AW'(tag) << IDXW) | AW'(idx);
    endfunction

    initial begin
        reset = 1; stall = 0; flush_all = 0; fill_valid = 0; fill_addr = '0;
        fill_prefetch = 0; lookup_valid = 0; lookup_addr = '0;
        mWalk = 1; mIdx = 0; mPend = 0; mPendHit = 0; mPendPf = 0;
        mPendAddr = '0; mFillCnt = 0; mHitCnt = 0;

        // First edge establishes reset state before any checks.
        @(posedge clk);
        #1;
        applyStimulus(1, 0, 0, '0, 0, 0, '0, 0);
        applyStimulus(1, 0, 0, '0, 0, 0, '0, 0);

        // Post-reset walk: 64 flush cycles then init_done.
        idle(LINES + 4);

        // Fill 0x40 prefetched while a lookup competes; lookup wins next cycle.
        applyStimulus(0, 0, 1, 26'h40, 1, 1, 26'h40, 0);
        applyStimulus(0, 0, 0, '0, 0, 1, 26'h40, 0);
        // Same index, different tag: hit then miss back to back.
        applyStimulus(0, 0, 0, '0, 0, 1, 26'h80, 0);
        idle(2);

        // Stall blocks the lookup but not the concurrent fill.
        applyStimulus(0, 0, 1, 26'h85, 0, 1, 26'h40, 1);
        applyStimulus(0, 0, 0, '0, 0, 1, 26'h40, 1);
        idle(1);

        // Lookup granted just before flush_all still responds.
        applyStimulus(0, 0, 0, '0, 0, 1, 26'h40, 0);
        applyStimulus(0, 1, 0, '0, 0, 0, '0, 0);
        idle(LINES + 2);
        applyStimulus(0, 0, 0, '0, 0, 1, 26'h40, 0);
        idle(2);

        // Reset in the middle of a walk restarts it from index 0.
        applyStimulus(0, 1, 0, '0, 0, 0, '0, 0);
        idle(20);
        applyStimulus(1, 0, 0, '0, 0, 0, '0, 0);
        idle(LINES + 2);

        // Randomized traffic over a small address pool so hits are common.
        for (int n = 0; n < 3000; n++) begin
            applyStimulus($urandom_range(0, 599) == 0,
                          $urandom_range(0, 149) == 0,
                          $urandom_range(0, 3) == 0,
                          mkAddr($urandom_range(0, 3), $urandom_range(0, 7)),
                          $urandom_range(0, 1) == 1,
                          $urandom_range(0, 1) == 1,
                          mkAddr($urandom_range(0, 3), $urandom_range(0, 7)),
                          $urandom_range(0, 3) == 0);
        end
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
